// File: rtl/mod_n_counter_if.sv
// Bus bundle for mod_n_counter: control inputs, load data, count and flag outputs.
// Clock and reset are kept as plain module ports.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             carry_in;
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             clear_flags;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             wrapped;
    logic             load_err;
    logic             overflow;

    // Driver side (testbench or upstream controller)
    modport master (
        output enable, carry_in, load, mode, data_in, clear_flags,
        input  data_out, carry_out, wrapped, load_err, overflow
    );

    // Counter side
    modport slave (
        input  enable, carry_in, load, mode, data_in, clear_flags,
        output data_out, carry_out, wrapped, load_err, overflow
    );
endinterface

// File: rtl/mod_n_counter.sv
// Cascadable modulo-N up/down counter with parallel load, wrap or saturate at
// the range ends, one-cycle event pulses and a sticky range-end flag.
module mod_n_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    mod_n_counter_if.slave   bus
);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $fatal(1, "mod_n_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrapped_q, wrapped_d;
    logic             load_err_q, load_err_d;
    logic             overflow_q, overflow_d;

    logic count_en;
    logic range_end;

    assign count_en  = bus.enable && bus.carry_in;
    assign range_end = bus.mode ? (cnt_q == '0) : (cnt_q == MAX_VAL);

    // Terminal-count strobe for the next stage; forced low during reset so a
    // downstream digit cannot see a stale carry.
    assign bus.carry_out = !reset && count_en && !bus.load && range_end;

    // Next-state: load beats count beats hold; a range-end sets the sticky flag
    // even when clear_flags is asserted on the same edge.
    always_comb begin
        cnt_d      = cnt_q;
        wrapped_d  = 1'b0;
        load_err_d = 1'b0;
        overflow_d = overflow_q && !bus.clear_flags;
        if (bus.load) begin
            if ({1'b0, bus.data_in} < MOD_EXT) begin
                cnt_d = bus.data_in;
            end else begin
                cnt_d      = MAX_VAL;
                load_err_d = 1'b1;
            end
        end else if (count_en) begin
            if (range_end) begin
                wrapped_d  = 1'b1;
                overflow_d = 1'b1;
                if (SATURATE == 0) begin
                    cnt_d = bus.mode ? MAX_VAL : '0;
                end
            end else if (bus.mode) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // State registers, cleared asynchronously so outputs drop without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.data_out = cnt_q;
    assign bus.wrapped  = wrapped_q;
    assign bus.load_err = load_err_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter: wrap, saturate, load,
// flag clearing, cascade and asynchronous reset.
module tb_mod_n_counter;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    mod_n_counter_if #(.WIDTH(4)) u_if ();
    mod_n_counter_if #(.WIDTH(4)) s_if ();
    mod_n_counter_if #(.WIDTH(4)) c0_if ();
    mod_n_counter_if #(.WIDTH(4)) c1_if ();

    mod_n_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) dut (
        .clock(clock), .reset(reset), .bus(u_if.slave));
    mod_n_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .bus(s_if.slave));
    mod_n_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) stage0 (
        .clock(clock), .reset(reset), .bus(c0_if.slave));
    mod_n_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) stage1 (
        .clock(clock), .reset(reset), .bus(c1_if.slave));

    assign c1_if.carry_in = c0_if.carry_out;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.enable = 1'b1; u_if.carry_in = 1'b1; u_if.mode = 1'b1;
        tick(); tick();
        n_total++; if (u_if.data_out !== 4'd0) $display("FAIL reset_data: got %0d expected 0", u_if.data_out); else n_pass++;
        n_total++; if (u_if.wrapped !== 1'b0) $display("FAIL reset_wrapped: got %0b expected 0", u_if.wrapped); else n_pass++;
        n_total++; if (u_if.load_err !== 1'b0) $display("FAIL reset_load_err: got %0b expected 0", u_if.load_err); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", u_if.overflow); else n_pass++;
        n_total++; if (u_if.carry_out !== 1'b0) $display("FAIL reset_carry_out: got %0b expected 0", u_if.carry_out); else n_pass++;
        u_if.enable = 1'b0; u_if.mode = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_up_wrap();
        int exp_cnt;
        int n_wrap;
        exp_cnt = 0;
        n_wrap = 0;
        u_if.enable = 1'b1; u_if.mode = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            #1;
            n_total++;
            if (u_if.carry_out !== (exp_cnt == 11)) $display("FAIL up_carry_out[%0d]: got %0b expected %0b", i, u_if.carry_out, (exp_cnt == 11));
            else n_pass++;
            tick();
            exp_cnt = (exp_cnt + 1) % 12;
            n_total++;
            if (u_if.data_out !== 4'(exp_cnt)) $display("FAIL up_data[%0d]: got %0d expected %0d", i, u_if.data_out, exp_cnt);
            else n_pass++;
            n_total++;
            if (u_if.wrapped !== (i == 12)) $display("FAIL up_wrapped[%0d]: got %0b expected %0b", i, u_if.wrapped, (i == 12));
            else n_pass++;
            if (u_if.wrapped === 1'b1) n_wrap++;
        end
        n_total++; if (n_wrap != 1) $display("FAIL up_wrap_count: got %0d expected 1", n_wrap); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b1) $display("FAIL up_overflow: got %0b expected 1", u_if.overflow); else n_pass++;
        u_if.enable = 1'b0;
    endtask

    task automatic test_down_wrap_clear();
        u_if.load = 1'b1; u_if.data_in = 4'd0; u_if.clear_flags = 1'b1;
        tick();
        u_if.load = 1'b0; u_if.clear_flags = 1'b0;
        n_total++; if (u_if.data_out !== 4'd0) $display("FAIL down_load0: got %0d expected 0", u_if.data_out); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b0) $display("FAIL down_pre_clear: got %0b expected 0", u_if.overflow); else n_pass++;
        u_if.mode = 1'b1; u_if.enable = 1'b1;
        #1;
        n_total++; if (u_if.carry_out !== 1'b1) $display("FAIL down_carry_out: got %0b expected 1", u_if.carry_out); else n_pass++;
        tick();
        u_if.enable = 1'b0;
        n_total++; if (u_if.data_out !== 4'd11) $display("FAIL down_wrap_data: got %0d expected 11", u_if.data_out); else n_pass++;
        n_total++; if (u_if.wrapped !== 1'b1) $display("FAIL down_wrapped: got %0b expected 1", u_if.wrapped); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b1) $display("FAIL down_overflow: got %0b expected 1", u_if.overflow); else n_pass++;
        u_if.clear_flags = 1'b1;
        tick();
        u_if.clear_flags = 1'b0;
        n_total++; if (u_if.overflow !== 1'b0) $display("FAIL clear_overflow: got %0b expected 0", u_if.overflow); else n_pass++;
        n_total++; if (u_if.wrapped !== 1'b0) $display("FAIL wrapped_one_cycle: got %0b expected 0", u_if.wrapped); else n_pass++;
        n_total++; if (u_if.data_out !== 4'd11) $display("FAIL hold_data: got %0d expected 11", u_if.data_out); else n_pass++;
    endtask

    task automatic test_clear_vs_set();
        // Count is 11 in down mode; flip to up with clear_flags on the same edge.
        u_if.mode = 1'b0; u_if.enable = 1'b1; u_if.clear_flags = 1'b1;
        tick();
        u_if.enable = 1'b0; u_if.clear_flags = 1'b0;
        n_total++; if (u_if.data_out !== 4'd0) $display("FAIL mode_switch_data: got %0d expected 0", u_if.data_out); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b1) $display("FAIL set_beats_clear: got %0b expected 1", u_if.overflow); else n_pass++;
    endtask

    task automatic test_load();
        u_if.enable = 1'b1; u_if.mode = 1'b0; u_if.load = 1'b1; u_if.data_in = 4'd5;
        tick();
        n_total++; if (u_if.data_out !== 4'd5) $display("FAIL load_priority: got %0d expected 5", u_if.data_out); else n_pass++;
        n_total++; if (u_if.load_err !== 1'b0) $display("FAIL load_ok_err: got %0b expected 0", u_if.load_err); else n_pass++;
        u_if.data_in = 4'd14;
        tick();
        n_total++; if (u_if.data_out !== 4'd11) $display("FAIL load_oor_data: got %0d expected 11", u_if.data_out); else n_pass++;
        n_total++; if (u_if.load_err !== 1'b1) $display("FAIL load_err_pulse: got %0b expected 1", u_if.load_err); else n_pass++;
        u_if.data_in = 4'd12;
        tick();
        n_total++; if (u_if.data_out !== 4'd11) $display("FAIL load_12_data: got %0d expected 11", u_if.data_out); else n_pass++;
        n_total++; if (u_if.load_err !== 1'b1) $display("FAIL load_12_err: got %0b expected 1", u_if.load_err); else n_pass++;
        u_if.data_in = 4'd3;
        #1;
        n_total++; if (u_if.carry_out !== 1'b0) $display("FAIL carry_masked_by_load: got %0b expected 0", u_if.carry_out); else n_pass++;
        tick();
        n_total++; if (u_if.data_out !== 4'd3) $display("FAIL load_3: got %0d expected 3", u_if.data_out); else n_pass++;
        n_total++; if (u_if.load_err !== 1'b0) $display("FAIL load_err_clear: got %0b expected 0", u_if.load_err); else n_pass++;
        n_total++; if (u_if.wrapped !== 1'b0) $display("FAIL load_no_wrap: got %0b expected 0", u_if.wrapped); else n_pass++;
        u_if.load = 1'b0;
        tick();
        n_total++; if (u_if.data_out !== 4'd4) $display("FAIL count_after_load: got %0d expected 4", u_if.data_out); else n_pass++;
        u_if.enable = 1'b0;
    endtask

    task automatic test_saturate();
        s_if.load = 1'b1; s_if.data_in = 4'd11;
        tick();
        s_if.load = 1'b0; s_if.enable = 1'b1; s_if.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (s_if.data_out !== 4'd11) $display("FAIL sat_up_data[%0d]: got %0d expected 11", i, s_if.data_out); else n_pass++;
            n_total++; if (s_if.wrapped !== 1'b1) $display("FAIL sat_up_wrapped[%0d]: got %0b expected 1", i, s_if.wrapped); else n_pass++;
        end
        n_total++; if (s_if.overflow !== 1'b1) $display("FAIL sat_overflow: got %0b expected 1", s_if.overflow); else n_pass++;
        s_if.enable = 1'b0; s_if.load = 1'b1; s_if.data_in = 4'd0;
        tick();
        s_if.load = 1'b0; s_if.enable = 1'b1; s_if.mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (s_if.data_out !== 4'd0) $display("FAIL sat_down_data[%0d]: got %0d expected 0", i, s_if.data_out); else n_pass++;
            n_total++; if (s_if.wrapped !== 1'b1) $display("FAIL sat_down_wrapped[%0d]: got %0b expected 1", i, s_if.wrapped); else n_pass++;
        end
        s_if.mode = 1'b0;
        tick();
        s_if.enable = 1'b0;
        n_total++; if (s_if.data_out !== 4'd1) $display("FAIL sat_leave_bottom: got %0d expected 1", s_if.data_out); else n_pass++;
    endtask

    task automatic test_cascade();
        int d0;
        int d1;
        d0 = 0;
        d1 = 0;
        n_total++;
        if (c0_if.data_out !== 4'd0 || c1_if.data_out !== 4'd0) $display("FAIL cascade_start: got %0d,%0d expected 0,0", c1_if.data_out, c0_if.data_out);
        else n_pass++;
        c0_if.enable = 1'b1; c0_if.mode = 1'b0;
        for (int i = 1; i <= 144; i++) begin
            tick();
            if (d0 == 11) begin
                d0 = 0;
                d1 = (d1 + 1) % 12;
            end else begin
                d0 = d0 + 1;
            end
            n_total++;
            if (c0_if.data_out !== 4'(d0) || c1_if.data_out !== 4'(d1))
                $display("FAIL cascade[%0d]: got %0d,%0d expected %0d,%0d", i, c1_if.data_out, c0_if.data_out, d1, d0);
            else n_pass++;
        end
        c0_if.enable = 1'b0;
        n_total++;
        if ({c1_if.data_out, c0_if.data_out} !== 8'h00) $display("FAIL cascade_final: got %0d,%0d expected 0,0", c1_if.data_out, c0_if.data_out);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        u_if.load = 1'b1; u_if.data_in = 4'd7;
        tick();
        u_if.load = 1'b0;
        n_total++; if (u_if.data_out !== 4'd7) $display("FAIL areset_pre: got %0d expected 7", u_if.data_out); else n_pass++;
        u_if.enable = 1'b1; u_if.mode = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (u_if.data_out !== 4'd0) $display("FAIL areset_data: got %0d expected 0", u_if.data_out); else n_pass++;
        n_total++; if (u_if.overflow !== 1'b0) $display("FAIL areset_overflow: got %0b expected 0", u_if.overflow); else n_pass++;
        n_total++; if (u_if.carry_out !== 1'b0) $display("FAIL areset_carry: got %0b expected 0", u_if.carry_out); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_total++; if (u_if.data_out !== 4'd1) $display("FAIL areset_first_edge: got %0d expected 1", u_if.data_out); else n_pass++;
        u_if.enable = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        u_if.enable = 1'b0; u_if.carry_in = 1'b1; u_if.load = 1'b0; u_if.mode = 1'b0;
        u_if.data_in = '0; u_if.clear_flags = 1'b0;
        s_if.enable = 1'b0; s_if.carry_in = 1'b1; s_if.load = 1'b0; s_if.mode = 1'b0;
        s_if.data_in = '0; s_if.clear_flags = 1'b0;
        c0_if.enable = 1'b0; c0_if.carry_in = 1'b1; c0_if.load = 1'b0; c0_if.mode = 1'b0;
        c0_if.data_in = '0; c0_if.clear_flags = 1'b0;
        c1_if.enable = 1'b1; c1_if.load = 1'b0; c1_if.mode = 1'b0;
        c1_if.data_in = '0; c1_if.clear_flags = 1'b0;

        test_reset();
        test_up_wrap();
        test_down_wrap_clear();
        test_clear_vs_set();
        test_load();
        test_saturate();
        test_cascade();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
